pwm_fader_multi: RTL and testbench
==================================

// Module: pwm_fader_multi
// PURPOSE
//   Multi-channel PWM generator with a hardware fade engine. Each channel ramps its
//   current duty toward a programmed target at a programmable step and rate. The
//   PWM compare point updates only at period boundaries, so outputs never glitch.
//   Drives LED/dimmer pins from the top-level tile. Targets load over a valid/ready port.
// PARAMETERS
//   NUM_CH   4   number of PWM channels (1..16)
//   WIDTH    8   duty/counter width; PWM period = 2**WIDTH clocks
//   PRESC_W  16  width of fade_period (fade tick prescaler)
// PORTS
//   clk          in   1                 system clock
//   rst          in   1                 reset, synchronous, active-high
//   en           in   1                 run enable; 0 freezes period counter and prescaler
//   fade_period  in   PRESC_W           fade tick every fade_period+1 enabled clocks
//   cfg_valid    in   1                 config write request
//   cfg_ready    out  1                 config write accept
//   cfg_ch       in   max(1,clog2(NUM_CH)) target channel index
//   cfg_target   in   WIDTH             target duty
//   cfg_step     in   WIDTH             per-tick step size; 0 = jump immediately
//   pwm_out      out  NUM_CH            PWM outputs, registered
//   busy         out  NUM_CH            1 while channel current duty != target
//   period_start out  1                 1-cycle pulse in the first cycle of each period
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high (rst).
// - Reset: every output is 0, including cfg_ready. cnt, presc, cur[], target[],
//   step[] and duty_act[] are cleared. Reset asserted mid-fade aborts the fade; the
//   next cycle shows all outputs at 0. cfg_ready = 1 from the first cycle after rst falls.
// - Period counter cnt (WIDTH bits): increments when en=1 and wraps 2**WIDTH-1 -> 0.
//   period_start is registered; it is 1 in the cycle after cnt wraps to 0.
// - Compare: pwm_out[i] <= (cnt < duty_act[i]) when en=1; the register holds when en=0.
//   Latency is 1 clk. duty_act=0 gives constant low. duty_act=2**WIDTH-1 gives high
//   for all but 1 clk of each period.
// - Shadowing: duty_act[i] <= f(cur[i]) only on the enabled cycle where cnt = 2**WIDTH-1,
//   so a new duty takes effect exactly at the wrap.
// - Prescaler: presc counts 0..fade_period while en=1. fade_tick = (presc==fade_period),
//   and presc returns to 0 on the tick. fade_period=0 gives a tick every enabled clock.
// - Fade on tick, per channel, computed in WIDTH+1 bits with no wrap:
//     step=0           : cur <= target
//     cur < target     : cur <= min(cur+step, target)
//     cur > target     : cur <= max(cur-step, target)   (clamped, never underflows)
//     cur = target     : hold
// - busy[i] <= (cur[i] != target[i]) is registered and updates every cycle.
// - Config handshake: a write is accepted when cfg_valid && cfg_ready. It stores
//   target[cfg_ch] and step[cfg_ch] on that edge; there is no back-pressure beyond reset.
//   cfg_ch >= NUM_CH: the write is accepted and discarded.
// - A write in the same cycle as fade_tick: the tick uses the old target/step, and the
//   new values apply from the next tick.
// - A write while fading reverses or retargets from the present cur; cur never jumps.
// CONFIGURATION
// - PWM_GAMMA_EN defined: f(c) = (c*c + c) >> WIDTH, computed in 2*WIDTH bits; an
//   approximate square-law perceptual curve. Fixed points: f(0)=0 and
//   f(2**WIDTH-1)=2**WIDTH-1. For WIDTH=8, f(128)=64.
// - PWM_GAMMA_EN undefined: f(c) = c (linear). No multiplier is synthesised.
// TESTING
// 1. WIDTH=8, en=1, fade_period=0. Write ch0 target=64 step=0 -> busy[0] pulses 1 clk.
//    After the next wrap, pwm_out[0] is high for exactly 64 of every 256 clks.
// 2. ch1 from 0: target=200, step=10, fade_period=3 -> cur rises by 10 every 4 clks and
//    reaches 200 after 20 ticks (80 clks) with no overshoot; busy[1] then falls.
// 3. ch1 from 200: target=3, step=7 -> cur steps 193,...,4,3. The final step is
//    clamped to 3 and never wraps below 0.
// 4. Write ch2 target=100 mid-period at cnt=50 -> pwm_out[2] is unchanged until cnt
//    wraps. It shows the new duty from the next period; period_start aligns with it.
// 5. Hold en=0 for 300 clks mid-fade -> cnt, presc, cur and pwm_out all freeze. On
//    resume, operation continues seamlessly.
//    With NUM_CH=3, a write to cfg_ch=3 changes nothing.
// 6. Assert rst mid-fade -> all outputs 0 next clk, cfg_ready=0 during reset.
//    With PWM_GAMMA_EN, cur=128 gives 64 high clks per period and cur=255 gives 255.

Source files
------------

// File: rtl/pwm_fader_multi.sv
// ---------------------------------------------------------------------------
// pwm_fader_multi
// Multi-channel PWM generator with a per-channel fade engine. Each channel's
// current duty (cur) ramps toward a programmed target by a programmed step on
// every fade tick. The compare point (duty_act) is refreshed only at the
// period wrap, so the PWM waveform never glitches mid-period.
//
// Optional feature macro: PWM_GAMMA_EN
//   defined   : duty_act = (cur*cur + cur) >> WIDTH  (approximate square law)
//   undefined : duty_act = cur                       (linear, no multiplier)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en           run enable; low freezes period counter, prescaler and fades
//   fade_period  fade tick every fade_period+1 enabled clocks
//   cfg_valid    config write request
//   cfg_ready    config write accept (0 only in/through reset)
//   cfg_ch       channel index for the write (>= NUM_CH is discarded)
//   cfg_target   target duty for the addressed channel
//   cfg_step     per-tick step for the addressed channel (0 = jump)
//   pwm_out      registered PWM outputs
//   busy         registered, 1 while a channel's cur != target
//   period_start registered pulse aligned with the first pwm_out cycle of a period
// ---------------------------------------------------------------------------
module pwm_fader_multi #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 16,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] fade_period,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [WIDTH-1:0]   cfg_target,
  input  logic [WIDTH-1:0]   cfg_step,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic [NUM_CH-1:0]  busy,
  output logic               period_start
);

  localparam int unsigned SQ_W = 2 * WIDTH;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]   cnt;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   cur      [NUM_CH];
  logic [WIDTH-1:0]   target   [NUM_CH];
  logic [WIDTH-1:0]   step     [NUM_CH];
  logic [WIDTH-1:0]   duty_act [NUM_CH];
  logic [WIDTH-1:0]   cur_nxt_c[NUM_CH];
  logic               fade_tick_c;
  logic               cfg_fire_c;

  // One fade step, evaluated one bit wider than WIDTH so neither the sum nor
  // the clamp threshold can wrap.
  function automatic logic [WIDTH-1:0] fade_next(input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] s);
    logic [WIDTH:0] c_x;
    logic [WIDTH:0] t_x;
    logic [WIDTH:0] s_x;
    c_x = {1'b0, c};
    t_x = {1'b0, t};
    s_x = {1'b0, s};
    if (s == '0) begin
      return t;
    end else if (c < t) begin
      return (c_x + s_x >= t_x) ? t : WIDTH'(c_x + s_x);
    end else if (c > t) begin
      // c - s would land at or below target: clamp to target instead.
      return (c_x <= t_x + s_x) ? t : WIDTH'(c - s);
    end
    return c;
  endfunction

  // Maps the fade value onto the compare threshold.
  function automatic logic [WIDTH-1:0] shape(input logic [WIDTH-1:0] c);
`ifdef PWM_GAMMA_EN
    logic [SQ_W-1:0] sq;
    sq = SQ_W'(c) * SQ_W'(c) + SQ_W'(c);
    return sq[SQ_W-1:WIDTH];
`else
    return c;
`endif
  endfunction

  // Fade tick and config accept strobes.
  always_comb begin
    fade_tick_c = en && (presc == fade_period);
    cfg_fire_c  = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);
  end

  // Candidate next cur for every channel; applied only on a fade tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cur_nxt_c[i] = fade_next(cur[i], target[i], step[i]);
    end
  end

  // Period counter, prescaler, compare outputs and period_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      presc        <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act[i] <= '0;
      end
    end else if (en) begin
      cnt          <= cnt + 1'b1;
      presc        <= fade_tick_c ? '0 : presc + 1'b1;
      // pwm_out lags cnt by one clock, so the pulse marks the cycle whose
      // pwm_out value came from cnt == 0.
      period_start <= (cnt == '0);
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= (cnt < duty_act[i]);
        if (cnt == CNT_MAX) begin
          duty_act[i] <= shape(cur[i]);
        end
      end
    end else begin
      period_start <= 1'b0;
    end
  end

  // Fade state, busy flags and config storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      busy      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i]    <= '0;
        target[i] <= '0;
        step[i]   <= '0;
      end
    end else begin
      cfg_ready <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        busy[i] <= (cur[i] != target[i]);
        if (fade_tick_c) begin
          cur[i] <= cur_nxt_c[i];
        end
      end
      // The tick above reads the pre-write target/step; a write landing on
      // the same edge takes effect from the next tick.
      if (cfg_fire_c) begin
        target[cfg_ch] <= cfg_target;
        step[cfg_ch]   <= cfg_step;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fader_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_fader_multi
// Drives pwm_fader_multi (NUM_CH=4) plus a NUM_CH=3 copy sharing its inputs.
// A behavioural model predicts every output each cycle; literal expectations
// pin reset values, busy pulse width and measured per-period duty counts.
// ---------------------------------------------------------------------------
module tb_pwm_fader_multi;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int PER = 1 << W;

`ifdef PWM_GAMMA_EN
  localparam int E64 = 16, E200 = 157, E3 = 0, E100 = 39, E128 = 64, E255 = 255;
`else
  localparam int E64 = 64, E200 = 200, E3 = 3, E100 = 100, E128 = 128, E255 = 255;
`endif

  logic        clk = 1'b0;
  logic        rst, en, cfg_valid;
  logic [15:0] fade_period;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_target, cfg_step;
  logic        cfg_ready, period_start, cfg_ready3, period_start3;
  logic [3:0]  pwm_out, busy;
  logic [2:0]  pwm3, busy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_fader_multi #(.NUM_CH(4), .WIDTH(8), .PRESC_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fade_period(fade_period),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_target(cfg_target), .cfg_step(cfg_step),
    .pwm_out(pwm_out), .busy(busy), .period_start(period_start));

  pwm_fader_multi #(.NUM_CH(3), .WIDTH(8), .PRESC_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .fade_period(fade_period),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch),
    .cfg_target(cfg_target), .cfg_step(cfg_step),
    .pwm_out(pwm3), .busy(busy3), .period_start(period_start3));

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int   m_cur[NCH], m_tgt[NCH], m_step[NCH], m_duty[NCH];
  int   m_cnt, m_presc;
  logic [3:0] e_pwm, e_busy;
  logic e_ps, e_ready;
  bit   seen_rst = 0;
  bit   m_tick;

  function automatic int gamma_f(input int c);
`ifdef PWM_GAMMA_EN
    return (c * c + c) / PER;
`else
    return c;
`endif
  endfunction

  function automatic int fade_f(input int c, input int t, input int s);
    if (s == 0) return t;
    if (c < t)  return (c + s < t) ? c + s : t;
    if (c > t)  return (c - s > t) ? c - s : t;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_duty[i] = 0;
      end
      m_cnt = 0; m_presc = 0;
      e_pwm = '0; e_busy = '0; e_ps = 1'b0; e_ready = 1'b0;
      seen_rst = 1;
    end else if (seen_rst) begin
      m_tick = en && (m_presc == int'(fade_period));
      for (int i = 0; i < NCH; i++) e_busy[i] = (m_cur[i] != m_tgt[i]);
      if (en) begin
        for (int i = 0; i < NCH; i++) begin
          e_pwm[i] = (m_cnt < m_duty[i]);
          if (m_cnt == PER - 1) m_duty[i] = gamma_f(m_cur[i]);
        end
        e_ps    = (m_cnt == 0);
        m_cnt   = (m_cnt + 1) % PER;
        m_presc = m_tick ? 0 : (m_presc + 1) % 65536;
      end else begin
        e_ps = 1'b0;
      end
      if (m_tick)
        for (int i = 0; i < NCH; i++) m_cur[i] = fade_f(m_cur[i], m_tgt[i], m_step[i]);
      if (cfg_valid && e_ready) begin
        m_tgt[cfg_ch]  = int'(cfg_target);
        m_step[cfg_ch] = int'(cfg_step);
      end
      e_ready = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (seen_rst) begin
      check("pwm_out", int'(pwm_out), int'(e_pwm));
      check("busy", int'(busy), int'(e_busy));
      check("period_start", int'(period_start), int'(e_ps));
      check("cfg_ready", int'(cfg_ready), int'(e_ready));
      check("pwm_out_3ch", int'(pwm3), int'(e_pwm[2:0]));
      check("busy_3ch", int'(busy3), int'(e_busy[2:0]));
      check("period_start_3ch", int'(period_start3), int'(e_ps));
      check("cfg_ready_3ch", int'(cfg_ready3), int'(e_ready));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cfg(input int ch, input int tgt, input int stp);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_target = 8'(tgt);
    cfg_step   = 8'(stp);
    cyc(1);
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int limit);
    int n = 0;
    while (n < limit && busy[ch] !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    if (busy[ch] !== 1'b0) check("busy_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  // High cycles of pwm_out[ch] over one full period starting at period_start.
  task automatic measure(input string name, input int ch, input int exp);
    int n = 0;
    int high = 0;
    bit found = 0;
    while (n < 2 * PER && !found) begin
      @(negedge clk);
      if (period_start) found = 1;
      n++;
    end
    if (!found) begin
      check({name, "_no_period_start"}, 0, 1);
    end else begin
      high = int'(pwm_out[ch]);
      repeat (PER - 1) begin
        @(negedge clk);
        high += int'(pwm_out[ch]);
      end
      check(name, high, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_busy;
    rst = 1'b1; en = 1'b0; fade_period = '0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_target = '0; cfg_step = '0;
    cyc(3);
    @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);
    @(negedge clk);
    check("ready_after_rst", int'(cfg_ready), 1);
    @(posedge clk); #1;
    en = 1'b1;

    // Immediate jump: busy pulses for exactly one clock.
    write_cfg(0, 64, 0);
    cnt_busy = 0;
    repeat (6) begin
      @(negedge clk);
      cnt_busy += int'(busy[0]);
    end
    check("jump_busy_pulse", cnt_busy, 1);
    @(posedge clk); #1;
    wait_idle(0, 10);
    measure("duty_ch0_64", 0, E64);

    // Ramp up with prescaler, then clamped ramp down.
    fade_period = 16'd3;
    write_cfg(1, 200, 10);
    wait_idle(1, 200);
    measure("duty_ch1_200", 1, E200);
    write_cfg(1, 3, 7);
    wait_idle(1, 200);
    measure("duty_ch1_3", 1, E3);

    // Mid-period write at cnt = 50.
    for (int k = 0; k < 2 * PER && m_cnt != 50; k++) cyc(1);
    write_cfg(2, 100, 0);
    wait_idle(2, 20);
    measure("duty_ch2_100", 2, E100);

    // Freeze mid-fade, then resume.
    write_cfg(3, 255, 1);
    cyc(100);
    en = 1'b0;
    cyc(300);
    en = 1'b1;
    wait_idle(3, 1500);
    measure("duty_ch3_255", 3, E255);
    write_cfg(0, 128, 0);
    wait_idle(0, 20);
    measure("duty_ch0_128", 0, E128);

    // Reset mid-fade.
    write_cfg(0, 0, 1);
    cyc(40);
    rst = 1'b1;
    cyc(1);
    @(negedge clk);
    check("midrst_pwm_out", int'(pwm_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_cfg_ready", int'(cfg_ready), 0);
    @(posedge clk); #1;

    // Randomized segments, each starting from reset with a new prescale.
    for (int seg = 0; seg < 3; seg++) begin
      rst = 1'b1;
      fade_period = 16'($urandom_range(0, 3));
      cyc(2);
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        en         = ($urandom_range(0, 15) != 0);
        cfg_valid  = ($urandom_range(0, 7) == 0);
        cfg_ch     = 2'($urandom_range(0, 3));
        cfg_target = 8'($urandom);
        cfg_step   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
        cyc(1);
      end
      cfg_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
